// File: rtl/uart_bit_sampler_if.sv
// Bus bundle between the rx pin driver and the uart_bit_sampler receive front end.
// Define UART_BSC_PARITY_EN to add the parity_odd / parity_err signals.
interface uart_bit_sampler_if #(
  parameter int DATA_BITS = 8
);
  logic                 sample_en;
  logic                 rx;
  logic [DATA_BITS-1:0] data_out;
  logic                 data_valid;
  logic                 frame_err;
  logic                 busy;
`ifdef UART_BSC_PARITY_EN
  logic                 parity_odd;
  logic                 parity_err;

  modport master (
    output sample_en, rx, parity_odd,
    input  data_out, data_valid, frame_err, busy, parity_err
  );
  modport slave (
    input  sample_en, rx, parity_odd,
    output data_out, data_valid, frame_err, busy, parity_err
  );
`else
  modport master (
    output sample_en, rx,
    input  data_out, data_valid, frame_err, busy
  );
  modport slave (
    input  sample_en, rx,
    output data_out, data_valid, frame_err, busy
  );
`endif
endinterface

// File: rtl/uart_bit_sampler.sv
// UART receive front end: oversampled start detect, 3-sample majority vote, framing.
// Optional parity bit checking is enabled by defining UART_BSC_PARITY_EN.
module uart_bit_sampler #(
  parameter int OVERSAMPLE  = 16,
  parameter int DATA_BITS   = 8,
  parameter int STOP_BITS   = 1,
  parameter int SYNC_STAGES = 2
) (
  input logic              clk,
  input logic              rst_n,
  uart_bit_sampler_if.slave bus
);
  localparam int SW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [SW-1:0] MID_LO = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] MID    = SW'(OVERSAMPLE / 2);
  localparam logic [SW-1:0] MID_HI = SW'(OVERSAMPLE / 2 + 1);
  localparam logic [SW-1:0] LAST   = SW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t               state, state_next;
  logic [SYNC_STAGES-1:0] sync;
  logic                 rx_s;
  logic [SW-1:0]        samp_cnt, samp_next;
  logic [BW-1:0]        bit_cnt;
  logic                 armed, v0, v1, vote, stop_bad;
  logic                 at_decide, at_wrap, data_done, last_stop;
  logic [DATA_BITS-1:0] shift, data_out;
  logic                 data_valid, frame_err;
`ifdef UART_BSC_PARITY_EN
  logic                 par_bit, par_bad, parity_err;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync <= '1;
    else        sync <= {sync[SYNC_STAGES-2:0], bus.rx};
  end

  assign rx_s      = sync[SYNC_STAGES-1];
  assign at_decide = bus.sample_en && (samp_cnt == MID_HI);
  assign at_wrap   = bus.sample_en && (samp_cnt == LAST);
  assign samp_next = (samp_cnt == LAST) ? '0 : samp_cnt + 1'b1;
  // The third sample is taken live on the decision tick rather than registered.
  assign vote      = (v0 & v1) | (v0 & rx_s) | (v1 & rx_s);
  assign data_done = (bit_cnt == BW'(DATA_BITS));
  assign last_stop = (bit_cnt == BW'(STOP_BITS - 1));
`ifdef UART_BSC_PARITY_EN
  assign par_bad   = ((^shift) ^ par_bit) != bus.parity_odd;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:   if (bus.sample_en && !rx_s && armed) state_next = START;
      START:  if (at_decide && vote) state_next = IDLE;
              else if (at_wrap)      state_next = DATA;
`ifdef UART_BSC_PARITY_EN
      DATA:   if (at_wrap && data_done) state_next = PARITY;
      PARITY: if (at_wrap) state_next = STOP;
`else
      DATA:   if (at_wrap && data_done) state_next = STOP;
`endif
      STOP:   if (at_decide && last_stop) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      samp_cnt   <= '0;
      bit_cnt    <= '0;
      armed      <= 1'b1;
      v0         <= 1'b0;
      v1         <= 1'b0;
      shift      <= '0;
      stop_bad   <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
`ifdef UART_BSC_PARITY_EN
      par_bit    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
`ifdef UART_BSC_PARITY_EN
      parity_err <= 1'b0;
`endif
      if (bus.sample_en) begin
        if (samp_cnt == MID_LO) v0 <= rx_s;
        if (samp_cnt == MID)    v1 <= rx_s;
        case (state)
          IDLE: begin
            // The start tick itself is index 0, so the following tick is index 1.
            samp_cnt <= (!rx_s && armed) ? SW'(1) : '0;
            bit_cnt  <= '0;
            stop_bad <= 1'b0;
            if (rx_s) armed <= 1'b1;
          end
          START: samp_cnt <= (at_decide && vote) ? '0 : samp_next;
          DATA: begin
            samp_cnt <= samp_next;
            if (at_decide) begin
              shift   <= {vote, shift[DATA_BITS-1:1]};
              bit_cnt <= bit_cnt + 1'b1;
            end else if (at_wrap && data_done) begin
              bit_cnt <= '0;
            end
          end
`ifdef UART_BSC_PARITY_EN
          PARITY: begin
            samp_cnt <= samp_next;
            if (at_decide) par_bit <= vote;
          end
`endif
          STOP: begin
            if (at_decide && last_stop) begin
              samp_cnt <= '0;
              bit_cnt  <= '0;
              data_out <= shift;
              if (stop_bad || !vote) begin
                frame_err <= 1'b1;
                armed     <= 1'b0;
              end else begin
                data_valid <= 1'b1;
              end
`ifdef UART_BSC_PARITY_EN
              parity_err <= par_bad;
`endif
            end else begin
              samp_cnt <= samp_next;
              if (at_decide && !vote) stop_bad <= 1'b1;
              if (at_wrap) bit_cnt <= bit_cnt + 1'b1;
            end
          end
          default: samp_cnt <= '0;
        endcase
      end
    end
  end

  assign bus.data_out   = data_out;
  assign bus.data_valid = data_valid;
  assign bus.frame_err  = frame_err;
  assign bus.busy       = (state != IDLE);
`ifdef UART_BSC_PARITY_EN
  assign bus.parity_err = parity_err;
`endif
endmodule

// File: tb/tb_uart_bit_sampler.sv
// Directed, table-driven bench for uart_bit_sampler (OS=16, 8 data bits, 1 stop).
// Parity checks are compiled in when UART_BSC_PARITY_EN is defined.
module tb_uart_bit_sampler;
  localparam int OS = 16;
`ifdef UART_BSC_PARITY_EN
  localparam int LAT = 172;
`else
  localparam int LAT = 156;
`endif

  typedef struct {
    logic [7:0] data;
    logic       stop_val;
    int         glitch;
    int         div;
    int         exp_valid;
    int         exp_err;
    logic [7:0] exp_data;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   fails = 0;
  int   dv_count = 0;
  int   fe_count = 0;
  int   dv_cyc = 0;
  int   frame_start = 0;
  vec_t vecs[7];
`ifdef UART_BSC_PARITY_EN
  int   pe_count = 0;
  logic par_force_en = 1'b0;
  logic par_force = 1'b0;
`endif

  uart_bit_sampler_if #(.DATA_BITS(8)) bus ();
  uart_bit_sampler dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Every result pulse must arrive with busy already low and never both kinds at once.
  always @(posedge clk) begin
    #1;
    if (bus.data_valid || bus.frame_err) begin
      checkOutput("busy_at_pulse", bus.busy, 0);
      checkOutput("pulse_exclusive", bus.data_valid & bus.frame_err, 0);
      if (bus.data_valid) begin
        dv_count++;
        dv_cyc = cyc;
      end
      if (bus.frame_err) fe_count++;
    end
`ifdef UART_BSC_PARITY_EN
    if (bus.parity_err) pe_count++;
`endif
  end

  task automatic drive_tick(input logic level, input int div);
    for (int d = 0; d < div; d++) begin
      @(negedge clk);
      bus.sample_en = (d == 0);
      bus.rx = level;
    end
  endtask

  task automatic idle_ticks(input int n);
    for (int i = 0; i < n; i++) drive_tick(1'b1, 1);
  endtask

  task automatic send_frame(input logic [7:0] data, input logic stop_val, input int glitch, input int div);
    logic [11:0] bits;
    int nbits;
    int t;
    logic lvl;
    bits = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = data[i];
    nbits = 9;
`ifdef UART_BSC_PARITY_EN
    bits[9] = par_force_en ? par_force : ((^data) ^ bus.parity_odd);
    nbits = 10;
`endif
    bits[nbits] = stop_val;
    nbits++;
    t = 0;
    for (int b = 0; b < nbits; b++) begin
      for (int j = 0; j < OS; j++) begin
        lvl = bits[b];
        if (t == glitch) lvl = ~lvl;
        drive_tick(lvl, div);
        if (t == 0) frame_start = cyc;
        t++;
      end
    end
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    int dv0;
    int fe0;
    dv0 = dv_count;
    fe0 = fe_count;
    send_frame(v.data, v.stop_val, v.glitch, v.div);
    idle_ticks(3 * OS);
    checkOutput($sformatf("vec%0d_valid", idx), dv_count - dv0, v.exp_valid);
    checkOutput($sformatf("vec%0d_ferr", idx), fe_count - fe0, v.exp_err);
    checkOutput($sformatf("vec%0d_data", idx), bus.data_out, v.exp_data);
  endtask

  initial begin
    int dv0;
    int fe0;
    int s;
    vec_t v;
    bus.sample_en = 1'b0;
    bus.rx = 1'b1;
`ifdef UART_BSC_PARITY_EN
    bus.parity_odd = 1'b0;
`endif
    // data, stop, glitch tick, ticks-per-cycle divider, #valid, #ferr, data_out
    vecs[0] = '{8'h55, 1'b1, -1,  1, 1, 0, 8'h55};
    vecs[1] = '{8'hA3, 1'b1, -1,  1, 1, 0, 8'hA3};
    vecs[2] = '{8'h00, 1'b1, 72,  1, 1, 0, 8'h00};
    vecs[3] = '{8'hFF, 1'b1, -1,  1, 1, 0, 8'hFF};
    vecs[4] = '{8'hC3, 1'b0, -1,  1, 0, 1, 8'hC3};
    vecs[5] = '{8'h96, 1'b1, -1,  2, 1, 0, 8'h96};
    vecs[6] = '{8'h5A, 1'b1, 152, 1, 1, 0, 8'h5A};

    repeat (3) @(negedge clk);
    checkOutput("reset_data_out", bus.data_out, 0);
    checkOutput("reset_data_valid", bus.data_valid, 0);
    checkOutput("reset_frame_err", bus.frame_err, 0);
    checkOutput("reset_busy", bus.busy, 0);
    rst_n = 1'b1;
    idle_ticks(4);

    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i], i);
      if (i == 0) checkOutput("first_frame_latency", dv_cyc - frame_start, LAT);
    end

    // False start: three low ticks, then rx recovers before the mid votes.
    dv0 = dv_count;
    fe0 = fe_count;
    drive_tick(1'b0, 1);
    s = cyc;
    drive_tick(1'b0, 1);
    drive_tick(1'b0, 1);
    for (int k = 0; k < 12; k++) begin
      drive_tick(1'b1, 1);
      if (cyc - s == 11) checkOutput("false_start_busy_before", bus.busy, 1);
      if (cyc - s == 12) checkOutput("false_start_busy_after", bus.busy, 0);
    end
    idle_ticks(OS);
    checkOutput("false_start_no_valid", dv_count - dv0, 0);
    checkOutput("false_start_no_ferr", fe_count - fe0, 0);

    // Break: one frame_err only, then re-arm on a single high tick.
    dv0 = dv_count;
    fe0 = fe_count;
    for (int k = 0; k < 12 * OS; k++) drive_tick(1'b0, 1);
    checkOutput("break_ferr", fe_count - fe0, 1);
    checkOutput("break_no_valid", dv_count - dv0, 0);
    checkOutput("break_data", bus.data_out, 0);
    checkOutput("break_busy", bus.busy, 0);
    drive_tick(1'b1, 1);
    v = '{8'hA3, 1'b1, -1, 1, 1, 0, 8'hA3};
    applyStimulus(v, 100);

    // Asynchronous reset in the middle of the data bits.
    for (int k = 0; k < OS; k++) drive_tick(1'b0, 1);
    for (int k = 0; k < 40; k++) drive_tick(1'b1, 1);
    checkOutput("mid_busy", bus.busy, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset_busy", bus.busy, 0);
    checkOutput("async_reset_data", bus.data_out, 0);
    checkOutput("async_reset_valid", bus.data_valid, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle_ticks(4);
    v = '{8'h3C, 1'b1, -1, 1, 1, 0, 8'h3C};
    applyStimulus(v, 101);

`ifdef UART_BSC_PARITY_EN
    begin
      int pe0;
      bus.parity_odd = 1'b1;
      par_force_en = 1'b1;
      par_force = 1'b1;
      pe0 = pe_count;
      v = '{8'h07, 1'b1, -1, 1, 1, 0, 8'h07};
      applyStimulus(v, 200);
      checkOutput("parity_bad_flag", pe_count - pe0, 1);
      par_force = 1'b0;
      pe0 = pe_count;
      applyStimulus(v, 201);
      checkOutput("parity_good_flag", pe_count - pe0, 0);
      par_force_en = 1'b0;
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
